// File: rtl/issue_scheduler_pkg.sv
// Shared instruction-type encodings and FSM state type for the dual-issue scheduler.
package issue_scheduler_pkg;

    localparam logic [9:0] ITYPE_ALU = 10'h001;
    localparam logic [9:0] ITYPE_BR  = 10'h002;
    localparam logic [9:0] ITYPE_MUL = 10'h004;
    localparam logic [9:0] ITYPE_DIV = 10'h008;
    localparam logic [9:0] ITYPE_LD  = 10'h010;
    localparam logic [9:0] ITYPE_ST  = 10'h020;

    typedef enum logic {S_IDLE, S_DIV_BUSY} issue_state_t;

    // Types that only pipe B can execute and that may not pair with each other
    function automatic logic is_heavy(input logic [9:0] t);
        return |(t & (ITYPE_DIV | ITYPE_MUL | ITYPE_LD | ITYPE_ST));
    endfunction

endpackage

// File: rtl/issue_pair_chk.sv
// Combinational check deciding whether slot1 may issue alongside slot0.
module issue_pair_chk
    import issue_scheduler_pkg::*;
(
    input  logic       s1_valid,
    input  logic [9:0] s0_type,
    input  logic [9:0] s1_type,
    input  logic [4:0] s0_rd,
    input  logic       s0_we,
    input  logic [4:0] s1_raddr1,
    input  logic [4:0] s1_raddr2,
    output logic       pair_ok
);

    logic fit;
    logic raw;
    logic both_heavy;

    always_comb begin
        fit        = (s0_type == ITYPE_ALU) || (s1_type == ITYPE_ALU);
        raw        = s0_we && (s0_rd != 5'd0)
                     && ((s0_rd == s1_raddr1) || (s0_rd == s1_raddr2));
        both_heavy = is_heavy(s0_type) && is_heavy(s1_type);
        pair_ok    = s1_valid && fit && !raw && !both_heavy;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: steering, load-use bubble, divider-busy FSM and watchdog.
// Optional perf counters are built when ISSUE_PERF_CNT_EN is defined.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DIV_MAX_CYC = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic        s1_valid,
    input  logic [9:0]  s0_type,
    input  logic [9:0]  s1_type,
    input  logic [4:0]  s0_raddr1,
    input  logic [4:0]  s0_raddr2,
    input  logic [4:0]  s1_raddr1,
    input  logic [4:0]  s1_raddr2,
    input  logic [4:0]  s0_rd,
    input  logic        s0_we,
    input  logic [4:0]  s1_rd,
    input  logic        s1_we,
    input  logic        flush_br,
    input  logic        stall_dcache,
    input  logic        div_done,
    output logic [1:0]  pop_cnt,
    output logic        swap,
    output logic        pipe_a_valid,
    output logic        pipe_b_valid,
    output logic        div_busy,
    output logic        div_timeout,
    output logic [31:0] perf_dual,
    output logic [31:0] perf_single,
    output logic [31:0] perf_bubble
);

    localparam int CW = $clog2(DIV_MAX_CYC + 1);

    issue_state_t state, state_nxt;
    logic [CW-1:0] div_cnt, cnt_nxt;
    logic          tmo_nxt;
    logic          ld_pend;
    logic [4:0]    ld_rd;
    logic          pair_ok;
    logic          can_issue;
    logic          lu_hit;
    logic          div_issue;
    logic          ld_issue;
    logic [4:0]    ld_rd_nxt;

    issue_pair_chk u_pair_chk (
        .s1_valid  (s1_valid),
        .s0_type   (s0_type),
        .s1_type   (s1_type),
        .s0_rd     (s0_rd),
        .s0_we     (s0_we),
        .s1_raddr1 (s1_raddr1),
        .s1_raddr2 (s1_raddr2),
        .pair_ok   (pair_ok)
    );

    always_comb begin
        pop_cnt      = 2'd0;
        swap         = 1'b0;
        pipe_a_valid = 1'b0;
        pipe_b_valid = 1'b0;
        can_issue    = !rst && s0_valid && !flush_br && !stall_dcache
                       && (state == S_IDLE);
        // A paired slot1 also counts as a would-issue consumer of ld_rd
        lu_hit       = ld_pend
                       && ((s0_raddr1 == ld_rd) || (s0_raddr2 == ld_rd)
                           || (pair_ok && ((s1_raddr1 == ld_rd)
                                           || (s1_raddr2 == ld_rd))));
        if (can_issue && !lu_hit) begin
            pop_cnt      = pair_ok ? 2'd2 : 2'd1;
            swap         = (s0_type != ITYPE_ALU);
            pipe_a_valid = pair_ok || (s0_type == ITYPE_ALU);
            pipe_b_valid = pair_ok || (s0_type != ITYPE_ALU);
        end
    end

    always_comb begin
        div_issue = (pop_cnt != 2'd0)
                    && ((s0_type == ITYPE_DIV)
                        || ((pop_cnt == 2'd2) && (s1_type == ITYPE_DIV)));
        ld_issue  = 1'b0;
        ld_rd_nxt = ld_rd;
        if ((pop_cnt != 2'd0) && (s0_type == ITYPE_LD)
            && s0_we && (s0_rd != 5'd0)) begin
            ld_issue  = 1'b1;
            ld_rd_nxt = s0_rd;
        end else if ((pop_cnt == 2'd2) && (s1_type == ITYPE_LD)
                     && s1_we && (s1_rd != 5'd0)) begin
            ld_issue  = 1'b1;
            ld_rd_nxt = s1_rd;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = div_cnt;
        tmo_nxt   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (div_issue) begin
                    state_nxt = S_DIV_BUSY;
                    cnt_nxt   = '0;
                end
            end
            S_DIV_BUSY: begin
                if (div_done || flush_br) begin
                    state_nxt = S_IDLE;
                end else if (div_cnt == CW'(DIV_MAX_CYC - 1)) begin
                    state_nxt = S_IDLE;
                    tmo_nxt   = 1'b1;
                end else begin
                    cnt_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            div_busy    <= 1'b0;
            div_timeout <= 1'b0;
            ld_pend     <= 1'b0;
            ld_rd       <= 5'd0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= cnt_nxt;
            div_busy    <= (state_nxt == S_DIV_BUSY);
            div_timeout <= tmo_nxt;
            if (flush_br) begin
                ld_pend <= 1'b0;
            end else if (!stall_dcache) begin
                ld_pend <= ld_issue;
                ld_rd   <= ld_rd_nxt;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dual   <= 32'd0;
            perf_single <= 32'd0;
            perf_bubble <= 32'd0;
        end else begin
            if (pop_cnt == 2'd2) perf_dual <= perf_dual + 32'd1;
            if (pop_cnt == 2'd1) perf_single <= perf_single + 32'd1;
            if (s0_valid && (pop_cnt == 2'd0) && !flush_br)
                perf_bubble <= perf_bubble + 32'd1;
        end
    end
`else
    assign perf_dual   = 32'd0;
    assign perf_single = 32'd0;
    assign perf_bubble = 32'd0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: driver pushes model predictions, monitor compares.
module tb_issue_scheduler;

    localparam int MAXC = 8;
    localparam logic [9:0] T_ALU = 10'h001;
    localparam logic [9:0] T_BR  = 10'h002;
    localparam logic [9:0] T_MUL = 10'h004;
    localparam logic [9:0] T_DIV = 10'h008;
    localparam logic [9:0] T_LD  = 10'h010;
    localparam logic [9:0] T_ST  = 10'h020;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s0_valid = 0, s1_valid = 0, s0_we = 0, s1_we = 0;
    logic [9:0] s0_type = T_ALU, s1_type = T_ALU;
    logic [4:0] s0_raddr1 = 0, s0_raddr2 = 0, s1_raddr1 = 0, s1_raddr2 = 0;
    logic [4:0] s0_rd = 0, s1_rd = 0;
    logic flush_br = 0, stall_dcache = 0, div_done = 0;
    logic [1:0] pop_cnt;
    logic swap, pipe_a_valid, pipe_b_valid, div_busy, div_timeout;
    logic [31:0] perf_dual, perf_single, perf_bubble;

    issue_scheduler #(.DIV_MAX_CYC(MAXC)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s1_valid(s1_valid),
        .s0_type(s0_type), .s1_type(s1_type),
        .s0_raddr1(s0_raddr1), .s0_raddr2(s0_raddr2),
        .s1_raddr1(s1_raddr1), .s1_raddr2(s1_raddr2),
        .s0_rd(s0_rd), .s0_we(s0_we), .s1_rd(s1_rd), .s1_we(s1_we),
        .flush_br(flush_br), .stall_dcache(stall_dcache), .div_done(div_done),
        .pop_cnt(pop_cnt), .swap(swap),
        .pipe_a_valid(pipe_a_valid), .pipe_b_valid(pipe_b_valid),
        .div_busy(div_busy), .div_timeout(div_timeout),
        .perf_dual(perf_dual), .perf_single(perf_single), .perf_bubble(perf_bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pop; int swp; int a; int b; int busy; int tmo;
        int pd; int ps; int pb;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_busy, m_tmo, m_ldp;
    int m_cnt, m_ldrd;
    int m_pd, m_ps, m_pb;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit heavy(input logic [9:0] t);
        return (t == T_DIV) || (t == T_MUL) || (t == T_LD) || (t == T_ST);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_tmo = 0; m_ldp = 0; m_cnt = 0; m_ldrd = 0;
        m_pd = 0; m_ps = 0; m_pb = 0;
    endtask

    // Predict this cycle's outputs from the current inputs, then advance the model
    task automatic predict();
        exp_t e;
        bit issue, pair, hz, s0alu;
        int pop;
        issue = !flush_br && !stall_dcache && !m_busy && s0_valid;
        s0alu = (s0_type == T_ALU);
        pair = s1_valid && (s0alu || s1_type == T_ALU)
               && !(s0_we && s0_rd != 0 && (s0_rd == s1_raddr1 || s0_rd == s1_raddr2))
               && !(heavy(s0_type) && heavy(s1_type));
        hz = m_ldp && (s0_raddr1 == m_ldrd || s0_raddr2 == m_ldrd
                       || (pair && (s1_raddr1 == m_ldrd || s1_raddr2 == m_ldrd)));
        pop = (!issue || hz) ? 0 : (pair ? 2 : 1);
        e.pop = pop;
        e.swp = (pop > 0) && !s0alu;
        e.a = (pop == 2) || (pop == 1 && s0alu);
        e.b = (pop == 2) || (pop == 1 && !s0alu);
        e.busy = m_busy;
        e.tmo = m_tmo;
`ifdef ISSUE_PERF_CNT_EN
        e.pd = m_pd; e.ps = m_ps; e.pb = m_pb;
`else
        e.pd = 0; e.ps = 0; e.pb = 0;
`endif
        q.push_back(e);
        if (pop == 2) m_pd++;
        if (pop == 1) m_ps++;
        if (s0_valid && pop == 0 && !flush_br) m_pb++;
        m_tmo = 0;
        if (m_busy) begin
            if (div_done || flush_br) m_busy = 0;
            else if (m_cnt == MAXC - 1) begin m_busy = 0; m_tmo = 1; end
            else m_cnt++;
        end else if (pop > 0 && (s0_type == T_DIV || (pop == 2 && s1_type == T_DIV))) begin
            m_busy = 1; m_cnt = 0;
        end
        if (flush_br) m_ldp = 0;
        else if (!stall_dcache) begin
            m_ldp = 0;
            if (pop > 0 && s0_type == T_LD && s0_we && s0_rd != 0) begin
                m_ldp = 1; m_ldrd = s0_rd;
            end else if (pop == 2 && s1_type == T_LD && s1_we && s1_rd != 0) begin
                m_ldp = 1; m_ldrd = s1_rd;
            end
        end
    endtask

    task automatic drive(input bit v0, input logic [9:0] t0, input int r01, input int r02,
                         input int rd0, input bit we0,
                         input bit v1, input logic [9:0] t1, input int r11, input int r12,
                         input int rd1, input bit we1,
                         input bit fl, input bit st, input bit dd);
        @(negedge clk);
        s0_valid = v0; s0_type = t0; s0_raddr1 = 5'(r01); s0_raddr2 = 5'(r02);
        s0_rd = 5'(rd0); s0_we = we0;
        s1_valid = v1; s1_type = t1; s1_raddr1 = 5'(r11); s1_raddr2 = 5'(r12);
        s1_rd = 5'(rd1); s1_we = we1;
        flush_br = fl; stall_dcache = st; div_done = dd;
        predict();
    endtask

    task automatic idle(input int n, input bit dd_last);
        for (int i = 0; i < n; i++)
            drive(1, T_ALU, 1, 2, 3, 1, 1, T_ALU, 4, 5, 6, 1, 0, 0, dd_last && i == n - 1);
    endtask

    function automatic logic [9:0] rtype();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0, 1, 2: return T_ALU;
            3: return T_BR;
            4: return T_MUL;
            5: return T_DIV;
            6: return T_LD;
            default: return T_ST;
        endcase
    endfunction

    // Monitor: compare every cycle that has a pending prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pop_cnt", pop_cnt, e.pop);
                chk("swap", swap, e.swp);
                chk("pipe_a_valid", pipe_a_valid, e.a);
                chk("pipe_b_valid", pipe_b_valid, e.b);
                chk("div_busy", div_busy, e.busy);
                chk("div_timeout", div_timeout, e.tmo);
                chk("perf_dual", perf_dual, e.pd);
                chk("perf_single", perf_single, e.ps);
                chk("perf_bubble", perf_bubble, e.pb);
            end
        end
    end

    initial begin
        logic [9:0] t0, t1;
        model_reset();
        s0_valid = 1;
        #12;
        chk("rst_pop_cnt", pop_cnt, 0);
        chk("rst_pipe_a", pipe_a_valid, 0);
        chk("rst_div_busy", div_busy, 0);
        chk("rst_perf_dual", perf_dual, 0);
        @(negedge clk);
        rst = 0;
        // directed cases
        drive(1, T_ALU, 1, 2, 3, 1, 1, T_LD, 5, 6, 9, 1, 0, 0, 0);
        drive(1, T_ALU, 1, 2, 3, 1, 1, T_ALU, 4, 3, 9, 1, 0, 0, 0);
        drive(1, T_ALU, 1, 2, 0, 1, 1, T_ALU, 4, 0, 9, 1, 0, 0, 0);
        drive(1, T_LD, 1, 2, 7, 1, 0, T_ALU, 4, 5, 9, 1, 0, 0, 0);
        drive(1, T_ALU, 7, 2, 8, 1, 0, T_ALU, 4, 5, 9, 1, 0, 0, 0);
        drive(1, T_ALU, 7, 2, 8, 1, 0, T_ALU, 4, 5, 9, 1, 0, 0, 0);
        drive(1, T_DIV, 1, 2, 10, 1, 0, T_ALU, 4, 5, 9, 1, 0, 0, 0);
        idle(5, 1);
        idle(2, 0);
        drive(1, T_DIV, 1, 2, 10, 1, 0, T_ALU, 4, 5, 9, 1, 0, 0, 0);
        idle(MAXC + 3, 0);
        drive(1, T_DIV, 1, 2, 10, 1, 0, T_ALU, 4, 5, 9, 1, 0, 0, 0);
        drive(1, T_LD, 1, 2, 7, 1, 1, T_ALU, 4, 5, 9, 1, 1, 0, 0);
        drive(1, T_DIV, 1, 2, 10, 1, 0, T_ALU, 4, 5, 9, 1, 1, 0, 0);
        idle(2, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            t0 = rtype();
            t1 = rtype();
            drive($urandom_range(0, 7) != 0, t0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  (t0 == T_LD) ? 1'b1 : 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, t1,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  (t1 == T_LD) ? 1'b1 : 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 11) == 0);
        end
        // asynchronous reset while the divider is busy
        drive(1, T_DIV, 1, 2, 10, 1, 0, T_ALU, 4, 5, 9, 1, 0, 0, 0);
        idle(3, 0);
        @(negedge clk);
        #4;
        chk("pre_rst_div_busy", div_busy, 1);
        rst = 1;
        #1;
        chk("async_rst_div_busy", div_busy, 0);
        chk("async_rst_pop_cnt", pop_cnt, 0);
        chk("async_rst_pipe_a", pipe_a_valid, 0);
        chk("async_rst_pipe_b", pipe_b_valid, 0);
        chk("async_rst_perf_single", perf_single, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        drive(1, T_ALU, 1, 2, 3, 1, 1, T_MUL, 5, 6, 9, 1, 0, 0, 0);
        idle(2, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
